// File: rtl/alu_multicycle.sv
// Multi-cycle RISC-V style ALU: one-cycle arithmetic/logic, shifts iterate one bit per cycle.
// Request/result use valid/ready handshakes; a single result is in flight at a time.
module alu_multicycle #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op5,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILL
  } op_t;

  state_t            state_q, state_d;
  op_t               sop_q, sop_d;
  logic [XLEN-1:0]   work_q, work_d;
  logic [SHW-1:0]    cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  op_t               op;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   work_sh;
  logic [SHW-1:0]    shamt;
  logic              is_shift;

  assign shamt = b[SHW-1:0];

  always_comb begin
    op = OP_ILL;
    case (alu_op)
      2'b00: op = OP_ADD;
      2'b01: op = OP_SUB;
      2'b10: begin
        case (funct3)
          3'b000: op = (op5 & funct7b5) ? OP_SUB : OP_ADD;
          3'b001: op = OP_SLL;
          3'b010: op = OP_SLT;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: op = funct7b5 ? OP_SRA : OP_SRL;
          3'b110: op = OP_OR;
          default: op = OP_AND;
        endcase
      end
      default: op = OP_ILL;
    endcase
  end

  assign is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);

  // Shift ops only reach this path with shamt == 0, where the result is a itself.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, a < b};
      OP_XOR:  alu_res = a ^ b;
      OP_OR:   alu_res = a | b;
      OP_AND:  alu_res = a & b;
      OP_SLL, OP_SRL, OP_SRA: alu_res = a;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    work_sh = work_q >> 1;
    case (sop_q)
      OP_SLL:  work_sh = work_q << 1;
      OP_SRA:  work_sh = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: work_sh = work_q >> 1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    sop_d     = sop_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          illegal_d = (op == OP_ILL);
          if (is_shift && shamt != '0) begin
            state_d = SHIFT;
            sop_d   = op;
            work_d  = a;
            cnt_d   = shamt;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
          end
        end
      end
      SHIFT: begin
        work_d = work_sh;
        cnt_d  = cnt_q - SHW'(1);
        // Result is published only when the last bit has moved, never a partial value.
        if (cnt_q == SHW'(1)) begin
          state_d  = DONE;
          result_d = work_sh;
          zero_d   = (work_sh == '0);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sop_q     <= OP_SRL;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sop_q     <= sop_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle: decode, shift latency, DONE hold, mid-shift reset.
// Latency below = cycles from the accept cycle to the first out_valid cycle (1 + shift steps).
module tb_alu_multicycle;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            op5 = 1'b0;
  logic [1:0]      alu_op = 2'b00;
  logic [2:0]      funct3 = 3'b000;
  logic            funct7b5 = 1'b0;
  logic [XLEN-1:0] a = '0;
  logic [XLEN-1:0] b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            illegal;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;

  alu_multicycle #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op5(op5), .alu_op(alu_op), .funct3(funct3), .funct7b5(funct7b5),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Drive a request and return just after its accept edge.
  task automatic accept(input logic o5, input logic [1:0] aop, input logic [2:0] f3,
                        input logic f7, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv);
    int guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    op5 = o5; alu_op = aop; funct3 = f3; funct7b5 = f7; a = av; b = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678;
  endtask

  task automatic wait_done(output int l);
    l = 1;
    while (!out_valid && l < 100) begin
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1 || illegal !== 1'b0)
      $display("FAIL reset_state: rdy=%b vld=%b res=%h zero=%b ill=%b, want 1 0 0 1 0",
               in_ready, out_valid, result, zero, illegal);
    else n_pass++;
  endtask

  task automatic test_sub_rtype();
    accept(1'b1, 2'b10, 3'b000, 1'b1, 32'd5, 32'd7);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'hFFFF_FFFE || zero !== 1'b0 || illegal !== 1'b0)
      $display("FAIL sub_rtype: lat=%0d res=%h zero=%b ill=%b, want 1 fffffffe 0 0", lat, result, zero, illegal);
    else n_pass++;
    take();
  endtask

  task automatic test_addi();
    accept(1'b0, 2'b10, 3'b000, 1'b1, 32'd5, 32'd7);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'd12 || zero !== 1'b0)
      $display("FAIL addi: lat=%0d res=%h zero=%b, want 1 0000000c 0", lat, result, zero);
    else n_pass++;
    take();
  endtask

  task automatic test_alu_op();
    accept(1'b0, 2'b00, 3'b111, 1'b1, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'd0 || zero !== 1'b1)
      $display("FAIL aluop_add_wrap: lat=%0d res=%h zero=%b, want 1 0 1", lat, result, zero);
    else n_pass++;
    take();
    accept(1'b0, 2'b01, 3'b000, 1'b0, 32'd3, 32'd10);
    wait_done(lat);
    n_checks++;
    if (result !== 32'hFFFF_FFF9 || zero !== 1'b0)
      $display("FAIL aluop_sub: res=%h zero=%b, want fffffff9 0", result, zero);
    else n_pass++;
    take();
    accept(1'b1, 2'b11, 3'b000, 1'b0, 32'd3, 32'd4);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'd0 || zero !== 1'b1 || illegal !== 1'b1)
      $display("FAIL illegal: lat=%0d res=%h zero=%b ill=%b, want 1 0 1 1", lat, result, zero, illegal);
    else n_pass++;
    take();
  endtask

  task automatic test_shifts();
    accept(1'b1, 2'b10, 3'b101, 1'b1, 32'h8000_0000, 32'h24);
    wait_done(lat);
    n_checks++;
    if (lat !== 5 || result !== 32'hF800_0000 || illegal !== 1'b0)
      $display("FAIL sra: lat=%0d res=%h ill=%b, want 5 f8000000 0", lat, result, illegal);
    else n_pass++;
    take();
    accept(1'b1, 2'b10, 3'b101, 1'b0, 32'h8000_0000, 32'h24);
    wait_done(lat);
    n_checks++;
    if (lat !== 5 || result !== 32'h0800_0000)
      $display("FAIL srl: lat=%0d res=%h, want 5 08000000", lat, result);
    else n_pass++;
    take();
    accept(1'b1, 2'b10, 3'b001, 1'b0, 32'h0000_0003, 32'hFFFF_FFE1);
    wait_done(lat);
    n_checks++;
    if (lat !== 2 || result !== 32'h0000_0006)
      $display("FAIL sll_1: lat=%0d res=%h, want 2 00000006", lat, result);
    else n_pass++;
    take();
    // Shift amount of zero (upper b bits ignored) completes like a plain op.
    accept(1'b1, 2'b10, 3'b001, 1'b0, 32'h0000_00A5, 32'h0000_0020);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'h0000_00A5)
      $display("FAIL sll_zero: lat=%0d res=%h, want 1 000000a5", lat, result);
    else n_pass++;
    take();
  endtask

  task automatic test_compare_logic();
    accept(1'b1, 2'b10, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    n_checks++;
    if (result !== 32'd1 || zero !== 1'b0)
      $display("FAIL slt: res=%h zero=%b, want 00000001 0", result, zero);
    else n_pass++;
    take();
    accept(1'b1, 2'b10, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1);
    wait_done(lat);
    n_checks++;
    if (result !== 32'd0 || zero !== 1'b1)
      $display("FAIL sltu: res=%h zero=%b, want 0 1", result, zero);
    else n_pass++;
    take();
    accept(1'b1, 2'b10, 3'b100, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    wait_done(lat);
    n_checks++;
    if (result !== 32'hF0F0_F0F0)
      $display("FAIL xor: res=%h, want f0f0f0f0", result);
    else n_pass++;
    take();
    accept(1'b1, 2'b10, 3'b111, 1'b0, 32'hFF00_FF00, 32'h0FF0_0FF0);
    wait_done(lat);
    n_checks++;
    if (result !== 32'h0F00_0F00)
      $display("FAIL and: res=%h, want 0f000f00", result);
    else n_pass++;
    take();
  endtask

  task automatic test_hold_back_to_back();
    int bad = 0;
    accept(1'b1, 2'b10, 3'b110, 1'b0, 32'hF0, 32'h0F);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'hFF)
      $display("FAIL or: lat=%0d res=%h, want 1 000000ff", lat, result);
    else n_pass++;
    // A new request waits while the result is not taken.
    op5 = 1'b0; alu_op = 2'b00; funct3 = 3'b000; funct7b5 = 1'b0; a = 32'd1; b = 32'd2;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (result !== 32'hFF || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0)
      $display("FAIL done_hold: %0d unstable cycles, res=%h rdy=%b vld=%b, want 0 000000ff 0 1",
               bad, result, in_ready, out_valid);
    else n_pass++;
    take();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL after_handshake: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    else n_pass++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'd3)
      $display("FAIL next_accept: vld=%b res=%h, want 1 00000003", out_valid, result);
    else n_pass++;
    take();
  endtask

  task automatic test_reset_mid_shift();
    accept(1'b1, 2'b10, 3'b001, 1'b0, 32'd1, 32'd31);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || zero !== 1'b1)
      $display("FAIL reset_async: rdy=%b vld=%b res=%h zero=%b, want 1 0 0 1", in_ready, out_valid, result, zero);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || illegal !== 1'b0)
      $display("FAIL reset_after: rdy=%b vld=%b res=%h ill=%b, want 1 0 0 0", in_ready, out_valid, result, illegal);
    else n_pass++;
    accept(1'b0, 2'b00, 3'b000, 1'b0, 32'd100, 32'd23);
    wait_done(lat);
    n_checks++;
    if (lat !== 1 || result !== 32'd123 || zero !== 1'b0)
      $display("FAIL add_after_reset: lat=%0d res=%h zero=%b, want 1 0000007b 0", lat, result, zero);
    else n_pass++;
    take();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_reset();
    test_sub_rtype();
    test_addi();
    test_alu_op();
    test_shifts();
    test_compare_logic();
    test_hold_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
